// File: rtl/dmem_responder.sv
// Data-memory slave: accepts one request strobe, waits a programmable latency,
// then reads or writes an internal word array and pulses mem_ready for one cycle.
module dmem_responder #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned WR_LAT     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] DMem_addr,
    input  logic [DATA_W-1:0] DMem_din,
    input  logic              DMem_rd,
    output logic [DATA_W-1:0] DMem_dout,
    output logic              mem_ready,
    output logic              busy,
    output logic              addr_err,
    output logic              overrun
);

    localparam int unsigned LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              mem_we;
    logic              out_of_range;
    logic [DEPTH_LOG2-1:0] idx;

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

    assign out_of_range = (addr_q[ADDR_W-1:DEPTH_LOG2] != '0);
    assign idx          = addr_q[DEPTH_LOG2-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        din_d     = din_q;
        rd_d      = rd_q;
        dout_d    = dout_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        overrun_d = overrun_q;
        mem_we    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (req_valid) begin
                    addr_d  = DMem_addr;
                    din_d   = DMem_din;
                    rd_d    = DMem_rd;
                    cnt_d   = DMem_rd ? RD_CNT : WR_CNT;
                    state_d = StWait;
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                // A strobe while busy is dropped; only the sticky flag records it.
                if (req_valid) overrun_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StDone;
                    ready_d = 1'b1;
                    err_d   = out_of_range;
                    if (rd_q) dout_d = out_of_range ? '0 : mem_q[idx];
                    else      mem_we = ~out_of_range;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StWait);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            rd_q      <= 1'b0;
            dout_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            rd_q      <= rd_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    // Array is not reset; the write enable is already squashed by the async state reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[idx] <= din_q;
    end

    assign DMem_dout = dout_q;
    assign mem_ready = ready_q;
    assign busy      = busy_q;
    assign addr_err  = err_q;
    assign overrun   = overrun_q;

endmodule
